// File: rtl/spi_master_ctrl.sv
// ----------------------------------------------------------------------------
// spi_master_ctrl
// Mode-0 SPI master that runs one WIDTH-bit transfer per accepted command to
// one of N_SLAVES slaves sharing SCLK/MOSI/MISO. Slaves are selected through
// an encoded SS bus in which the value N_SLAVES means "nobody selected".
//
// Ports
//   clk, rst       system clock (rising edge), asynchronous active-low reset
//   cmd_valid/ready command handshake; cmd_ready is decoded from state
//   cmd_slave      target slave index (>= N_SLAVES is rejected)
//   cmd_data       word to transmit, MSB first
//   rsp_valid      one-cycle strobe when a command completes
//   rsp_data       word captured from MISO, held until the next strobe
//   rsp_err        qualifies rsp_valid: command rejected, bus untouched
//   busy           high whenever the controller is not idle
//   SCLK/MOSI/MISO SPI bus, SCLK idles low
//   SS             encoded slave select
// ----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned N_SLAVES = 4,
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned SS_W     = $clog2(N_SLAVES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [SS_W-1:0]  cmd_slave,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             rsp_valid,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,
    output logic             busy,
    output logic             SCLK,
    output logic             MOSI,
    input  logic             MISO,
    output logic [SS_W-1:0]  SS
);

    localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned BIT_W = $clog2(WIDTH);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
    localparam logic [SS_W-1:0]  SS_NONE  = SS_W'(N_SLAVES);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] ERR   = 3'd1;
    localparam logic [2:0] SETUP = 3'd2;
    localparam logic [2:0] SHIFT = 3'd3;
    localparam logic [2:0] HOLD  = 3'd4;
    localparam logic [2:0] DONE  = 3'd5;

    logic [2:0]       state_q,     state_d;
    logic [DIV_W-1:0] div_q,       div_d;
    logic [BIT_W-1:0] bit_q,       bit_d;
    logic [WIDTH-1:0] tx_q,        tx_d;
    logic [WIDTH-1:0] rx_q,        rx_d;
    logic             sclk_q,      sclk_d;
    logic             mosi_q,      mosi_d;
    logic [SS_W-1:0]  ss_q,        ss_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_err_q,   rsp_err_d;
    logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
    logic             busy_q,      busy_d;

    // Only combinational output: readiness is a pure decode of the state.
    assign cmd_ready = (state_q == IDLE);

    assign SCLK      = sclk_q;
    assign MOSI      = mosi_q;
    assign SS        = ss_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b0;
            ss_q        <= SS_NONE;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            ss_q        <= ss_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_data_q  <= rsp_data_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        sclk_d      = sclk_q;
        mosi_d      = mosi_q;
        ss_d        = ss_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_data_d  = rsp_data_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    if (cmd_slave < SS_NONE) begin
                        state_d = SETUP;
                        ss_d    = cmd_slave;
                        sclk_d  = 1'b0;
                        div_d   = '0;
                        bit_d   = '0;
                        // MSB goes straight onto MOSI; tx holds the rest left-aligned.
                        mosi_d  = cmd_data[WIDTH-1];
                        tx_d    = {cmd_data[WIDTH-2:0], 1'b0};
                    end else begin
                        state_d = ERR;
                    end
                end
            end

            ERR: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = IDLE;
            end

            SETUP: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    sclk_d  = 1'b1;
                    state_d = SHIFT;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + DIV_W'(1);
                end else begin
                    div_d = '0;
                    if (sclk_q) begin
                        // End of high phase: capture MISO, drop SCLK, advance MOSI.
                        rx_d   = {rx_q[WIDTH-2:0], MISO};
                        sclk_d = 1'b0;
                        if (bit_q != BIT_LAST) begin
                            mosi_d = tx_q[WIDTH-1];
                            tx_d   = {tx_q[WIDTH-2:0], 1'b0};
                        end
                    end else if (bit_q == BIT_LAST) begin
                        state_d = HOLD;
                    end else begin
                        bit_d  = bit_q + BIT_W'(1);
                        sclk_d = 1'b1;
                    end
                end
            end

            HOLD: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    ss_d    = SS_NONE;
                    state_d = DONE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            DONE: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b0;
                rsp_data_d  = rx_q;
                state_d     = IDLE;
            end

            default: begin
                state_d = IDLE;
                ss_d    = SS_NONE;
                sclk_d  = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI master controller that sequences single-word transfers to one of N_SLAVES slave devices on a shared SCLK/MOSI/MISO bus.
- Accepts a command (slave index + write word) through a valid/ready handshake and drives SCLK, MOSI and the encoded SS bus.
- Returns the captured MISO word with a one-cycle response strobe.
- Sits between the system-side command source and the bus of spi slaves, which compare the encoded SS value against their own slave number.

Parameters:
- WIDTH, 8, bits per transfer; must be >= 2.
- N_SLAVES, 4, number of addressable slaves.
- CLK_DIV, 4, clk cycles per SCLK half-period (D); must be >= 1.
- SS_W, $clog2(N_SLAVES+1), width of the encoded slave-select bus.

Ports:
- clk  in  1  system clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  controller can accept a command.
- cmd_slave  in  SS_W  target slave index.
- cmd_data  in  WIDTH  word to shift out, MSB first.
- rsp_valid  out  1  one-cycle strobe: transfer finished.
- rsp_data  out  WIDTH  word captured from MISO; held until the next rsp_valid.
- rsp_err  out  1  valid with rsp_valid: command rejected, no bus activity.
- busy  out  1  high in every state except IDLE.
- SCLK  out  1  SPI clock; idles low.
- MOSI  out  1  master data out.
- MISO  in  1  slave data in.
- SS  out  SS_W  encoded selected-slave number; the value N_SLAVES means none selected.

Behaviour:
- Reset (rst=0, async): state=IDLE; SCLK=0, MOSI=0, SS=N_SLAVES, rsp_valid=0, rsp_err=0, rsp_data=0, busy=0, cmd_ready=1 once rst is released. Reset mid-transfer immediately deselects (SS=N_SLAVES) and discards the transfer; no response is issued.
- SPI mode 0:
  - MOSI changes only while SCLK is low.
  - MISO is sampled on the last clk edge of each SCLK-high half-period.
  - MSB first.
- Handshake:
  - cmd_ready=1 only in IDLE.
  - A command is accepted on a clk edge where cmd_valid & cmd_ready; cmd_slave and cmd_data are latched on that edge.
  - Inputs are ignored while busy.
- States:
  - IDLE: if accepted and cmd_slave < N_SLAVES, go to SETUP with SS=cmd_slave, MOSI=cmd_data[WIDTH-1], SCLK=0. If accepted and cmd_slave >= N_SLAVES, go to ERR.
  - ERR (1 cycle): rsp_valid=1, rsp_err=1; rsp_data unchanged; SS stays N_SLAVES; go to IDLE.
  - SETUP (D cycles): SS asserted, SCLK=0; go to SHIFT with SCLK rising.
  - SHIFT (2*WIDTH*D cycles): each bit is D cycles with SCLK=1, then D cycles with SCLK=0.
    - At the end of each high phase, shift MISO into the receive register LSB.
    - At the start of each low phase except the last, present the next MOSI bit.
    - The bit counter counts 0..WIDTH-1; the divide counter counts 0..D-1 and wraps.
  - HOLD (D cycles): SCLK=0, SS still asserted, MOSI held.
  - DONE (1 cycle): SS=N_SLAVES, rsp_valid=1, rsp_err=0, rsp_data=received word; go to IDLE.
- Latency: rsp_valid is high in the cycle starting 1 + D*(2*WIDTH+2) edges after the accept edge (73 for the defaults).
- Inter-transfer gap: SS is deasserted for at least 2 cycles (DONE + IDLE) between back-to-back transfers.
- All outputs are registered; there are no combinational paths from inputs to outputs except cmd_ready (decoded from state).

Test Plan:
1. Defaults, MISO looped to MOSI, cmd slave=2, data=0xA5 -> SS=2 for exactly 72 cycles; 8 SCLK rising edges, each 8 cycles apart; rsp_valid at accept+73 with rsp_data=0xA5, rsp_err=0.
2. Slave model on SS==1 returning 0x3C, cmd data=0xF0 -> model receives 0xF0; rsp_data=0x3C; MOSI stable throughout every SCLK-high phase.
3. cmd slave=5 (>= N_SLAVES) -> cmd_ready low for 1 cycle; rsp_valid=1, rsp_err=1 at accept+1; SS stays 4; SCLK never toggles.
4. cmd_valid held high with two commands (slave 0 data 0x01, then slave 3 data 0x80) -> second accepted in the cycle after DONE; SS=4 for 2 cycles between transfers; both responses correct.
5. Assert rst=0 at bit 4 of a transfer -> SS=4, SCLK=0, busy=0 immediately (without a clk edge); no rsp_valid; a new command after release completes normally.
6. CLK_DIV=1, WIDTH=16, loopback data 0x8001 -> SCLK toggles every clk; rsp_valid at accept+35 with rsp_data=0x8001.
